// File: rtl/vga_color_gen.sv
// vga_color_gen: per-pixel colour generator with SOLID / BARS / GRADIENT test patterns.
// Ports: clk (pixel clock), reset (async, active-high), h_counter/v_counter (scan position),
//        btn_r/btn_g/btn_b (channel level increment), btn_mode (mode advance),
//        vga_r/vga_g/vga_b (registered colour), mode (0 SOLID, 1 BARS, 2 GRADIENT).
// Build option: define VGA_COLOR_GEN_BARS_EN to include the BARS mode and its px/bi counters.
module vga_color_gen #(
    parameter int CW        = 4,
    parameter int HCW       = 11,
    parameter int H_START   = 144,
    parameter int H_END     = 783,
    parameter int V_START   = 35,
    parameter int V_END     = 514,
    parameter int BAR_W     = 80,
    parameter int GRAD_STEP = 40
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [HCW-1:0] h_counter,
    input  logic [HCW-1:0] v_counter,
    input  logic           btn_r,
    input  logic           btn_g,
    input  logic           btn_b,
    input  logic           btn_mode,
    output logic [CW-1:0]  vga_r,
    output logic [CW-1:0]  vga_g,
    output logic [CW-1:0]  vga_b,
    output logic [1:0]     mode
);
    localparam logic [HCW-1:0] HS = HCW'(H_START);
    localparam logic [HCW-1:0] HE = HCW'(H_END);
    localparam logic [HCW-1:0] VS = HCW'(V_START);
    localparam logic [HCW-1:0] VE = HCW'(V_END);
    localparam int GW = $clog2(GRAD_STEP + 1);
    localparam logic [GW-1:0] SC_LAST = GW'(GRAD_STEP - 1);
    localparam logic [CW-1:0] LVL_MAX = '1;

    if (BAR_W < 1 || GRAD_STEP < 1) begin : g_bad_param
        $error("vga_color_gen: BAR_W and GRAD_STEP must be at least 1");
    end

    logic [3:0]    hist_q;
    logic          arm_q;
    logic [3:0]    edge_w;
    logic [CW-1:0] lvl_r_q, lvl_g_q, lvl_b_q, lvl_r_d, lvl_g_d, lvl_b_d;
    logic [1:0]    pend_q, pend_d, mode_q, mode_d, pend_adv;
    logic [GW-1:0] sc_q, sc_d;
    logic [CW-1:0] gr_q, gr_d;
    logic [CW-1:0] vga_r_q, vga_g_q, vga_b_q, vga_r_d, vga_g_d, vga_b_d;
    logic [CW-1:0] s_r, s_g, s_b;
    logic          vis, frame_start;

    // arm_q holds edges off for the first cycle after reset so a button held through release is not counted
    assign edge_w      = {btn_mode, btn_b, btn_g, btn_r} & ~hist_q & {4{arm_q}};
    assign vis         = h_counter >= HS && h_counter <= HE && v_counter >= VS && v_counter <= VE;
    assign frame_start = h_counter == '0 && v_counter == '0;

    always_comb begin
        lvl_r_d = lvl_r_q + CW'(edge_w[0]);
        lvl_g_d = lvl_g_q + CW'(edge_w[1]);
        lvl_b_d = lvl_b_q + CW'(edge_w[2]);
`ifdef VGA_COLOR_GEN_BARS_EN
        pend_adv = pend_q == 2'd2 ? 2'd0 : pend_q + 2'd1;
`else
        pend_adv = pend_q == 2'd0 ? 2'd2 : 2'd0;
`endif
        pend_d = edge_w[3] ? pend_adv : pend_q;
        // the active mode takes the pending value as it stood before any edge in this same cycle
        mode_d = frame_start ? pend_q : mode_q;
        sc_d   = !vis ? '0 : (sc_q == SC_LAST ? '0 : sc_q + GW'(1));
        gr_d   = !vis ? '0 : ((sc_q == SC_LAST && gr_q != LVL_MAX) ? gr_q + CW'(1) : gr_q);
    end

`ifdef VGA_COLOR_GEN_BARS_EN
    localparam int PW = $clog2(BAR_W + 1);
    localparam logic [PW-1:0] PX_LAST = PW'(BAR_W - 1);
    logic [PW-1:0] px_q, px_d;
    logic [2:0]    bi_q, bi_d;
    logic          bars;

    always_comb begin
        px_d = !vis ? '0 : (px_q == PX_LAST ? '0 : px_q + PW'(1));
        bi_d = !vis ? '0 : ((px_q == PX_LAST && bi_q != 3'd7) ? bi_q + 3'd1 : bi_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            px_q <= '0;
            bi_q <= '0;
        end else begin
            px_q <= px_d;
            bi_q <= bi_d;
        end
    end

    // bar index bits gate channels so the bars run white, yellow, cyan, green, magenta, red, blue, black
    assign bars = mode_q == 2'd1;
    assign s_r  = (bars && bi_q[1]) ? '0 : lvl_r_q;
    assign s_g  = (bars && bi_q[2]) ? '0 : lvl_g_q;
    assign s_b  = (bars && bi_q[0]) ? '0 : lvl_b_q;
`else
    assign s_r = lvl_r_q;
    assign s_g = lvl_g_q;
    assign s_b = lvl_b_q;
`endif

    always_comb begin
        vga_r_d = !vis ? '0 : (mode_q == 2'd2 ? gr_q : s_r);
        vga_g_d = !vis ? '0 : (mode_q == 2'd2 ? gr_q : s_g);
        vga_b_d = !vis ? '0 : (mode_q == 2'd2 ? gr_q : s_b);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q  <= '0;
            arm_q   <= 1'b0;
            lvl_r_q <= '0;
            lvl_g_q <= '0;
            lvl_b_q <= '0;
            pend_q  <= '0;
            mode_q  <= '0;
            sc_q    <= '0;
            gr_q    <= '0;
            vga_r_q <= '0;
            vga_g_q <= '0;
            vga_b_q <= '0;
        end else begin
            hist_q  <= {btn_mode, btn_b, btn_g, btn_r};
            arm_q   <= 1'b1;
            lvl_r_q <= lvl_r_d;
            lvl_g_q <= lvl_g_d;
            lvl_b_q <= lvl_b_d;
            pend_q  <= pend_d;
            mode_q  <= mode_d;
            sc_q    <= sc_d;
            gr_q    <= gr_d;
            vga_r_q <= vga_r_d;
            vga_g_q <= vga_g_d;
            vga_b_q <= vga_b_d;
        end
    end

    assign vga_r = vga_r_q;
    assign vga_g = vga_g_q;
    assign vga_b = vga_b_q;
    assign mode  = mode_q;
endmodule

// File: tb/tb_vga_color_gen.sv
// tb_vga_color_gen: directed self-checking bench for vga_color_gen.
module tb_vga_color_gen;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] h_counter = '0;
    logic [10:0] v_counter = '0;
    logic        btn_r = 1'b0, btn_g = 1'b0, btn_b = 1'b0, btn_mode = 1'b0;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic [1:0]  mode;
    int          n_cmp = 0;
    int          n_err = 0;
    int          hc = 0;
    int          vc = 0;
`ifdef VGA_COLOR_GEN_BARS_EN
    localparam int MP = 2;
`else
    localparam int MP = 1;
`endif

    vga_color_gen dut (
        .clk(clk), .reset(reset), .h_counter(h_counter), .v_counter(v_counter),
        .btn_r(btn_r), .btn_g(btn_g), .btn_b(btn_b), .btn_mode(btn_mode),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .mode(mode)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    task automatic chk_rgb(input string tag, input int r, input int g, input int b);
        chk({tag, "_r"}, 32'(vga_r), r);
        chk({tag, "_g"}, 32'(vga_g), g);
        chk({tag, "_b"}, 32'(vga_b), b);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input int h, input int v);
        hc = h;
        vc = v;
        h_counter = 11'(h);
        v_counter = 11'(v);
        tick();
    endtask

    task automatic adv(input int to);
        while (hc < to) pix(hc + 1, vc);
    endtask

    task automatic pulse(input logic r, input logic g, input logic b, input logic m);
        {btn_r, btn_g, btn_b, btn_mode} = {r, g, b, m};
        pix(10, 600);
        {btn_r, btn_g, btn_b, btn_mode} = 4'b0;
        pix(10, 600);
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #3 reset = 1'b0;
        pix(10, 600);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_rgb("rst", 0, 0, 0);
        chk("rst_mode", 32'(mode), 0);
        reset = 1'b0;
        pix(10, 600);
        repeat (3) pulse(1, 0, 0, 0);
        chk("solid_mode", 32'(mode), 0);
        pix(200, 100);
        chk_rgb("solid_r3", 3, 0, 0);
        repeat (16) pulse(0, 1, 0, 0);
        pix(200, 100);
        chk_rgb("g_wrap", 3, 0, 0);
        do_reset();
        pulse(1, 1, 1, 0);
        pix(200, 100);
        chk_rgb("all_one", 1, 1, 1);
        repeat (14) pulse(1, 1, 1, 0);
        pix(500, 300);
        chk_rgb("lvl15", 15, 15, 15);
        pix(500, 20);
        chk_rgb("solid_vblank", 0, 0, 0);
        pix(143, 300);
        chk_rgb("solid_hleft", 0, 0, 0);
`ifdef VGA_COLOR_GEN_BARS_EN
        pulse(0, 0, 0, 1);
        chk("bars_pend", 32'(mode), 0);
        pix(0, 0);
        chk("bars_mode", 32'(mode), 1);
        pix(140, 100);
        adv(144); chk_rgb("white144", 15, 15, 15);
        adv(223); chk_rgb("white223", 15, 15, 15);
        adv(224); chk_rgb("yellow", 15, 15, 0);
        adv(304); chk_rgb("cyan", 0, 15, 15);
        adv(384); chk_rgb("green", 0, 15, 0);
        adv(464); chk_rgb("magenta", 15, 0, 15);
        adv(544); chk_rgb("red", 15, 0, 0);
        adv(624); chk_rgb("blue", 0, 0, 15);
        adv(704); chk_rgb("black704", 0, 0, 0);
        adv(784); chk_rgb("bars_h784", 0, 0, 0);
        pix(140, 101);
        adv(144); chk_rgb("white_l2", 15, 15, 15);
`endif
        do_reset();
        repeat (MP) pulse(0, 0, 0, 1);
        chk("grad_pend", 32'(mode), 0);
        pix(0, 0);
        chk("grad_mode", 32'(mode), 2);
        pix(140, 100);
        adv(144); chk_rgb("grad144", 0, 0, 0);
        adv(183); chk_rgb("grad183", 0, 0, 0);
        adv(184); chk_rgb("grad184", 1, 1, 1);
        adv(743); chk_rgb("grad743", 14, 14, 14);
        adv(744); chk_rgb("grad744", 15, 15, 15);
        adv(783); chk_rgb("grad783", 15, 15, 15);
        adv(784); chk_rgb("grad784", 0, 0, 0);
        pix(300, 20); chk_rgb("grad_v20", 0, 0, 0);
        pix(140, 200);
        adv(300); chk_rgb("grad300", 3, 3, 3);
        btn_b = 1'b1;
        #2 reset = 1'b1;
        #1;
        chk_rgb("async_rst", 0, 0, 0);
        chk("async_rst_mode", 32'(mode), 0);
        #2 reset = 1'b0;
        pix(301, 200); chk_rgb("post_rst", 0, 0, 0);
        btn_b = 1'b0;
        pix(302, 200); chk_rgb("held_b", 0, 0, 0);
        pulse(0, 0, 1, 0);
        pix(303, 200); chk_rgb("fresh_b", 0, 0, 1);
        repeat (MP) pulse(0, 0, 0, 1);
        pix(0, 0);
        chk("fs_mode2", 32'(mode), 2);
        btn_mode = 1'b1;
        pix(0, 0);
        btn_mode = 1'b0;
        chk("edge_at_fs", 32'(mode), 2);
        pix(10, 600);
        pix(0, 0);
        chk("edge_next_fs", 32'(mode), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
